// File: rtl/dut_vector_engine_pkg.sv
// Shared types and vector-byte field positions for the vector test engine.
package dve_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT_RD,
      SETTLE,
      CHECK,
      FINISH
   } state_t;

   localparam int unsigned VEC_W     = 8;
   localparam int unsigned DRIVE_LSB = 0;

   // The expected-output field sits directly above the drive field.
   function automatic int unsigned expect_lsb(input int unsigned n_in);
      return DRIVE_LSB + n_in;
   endfunction

endpackage

// File: rtl/dut_vector_engine_if.sv
// Vector memory read bus: engine is master, memory is slave (one-cycle read latency).
interface dut_vector_engine_if #(
   parameter int unsigned ADDR_W = 16
) ();
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en;
   logic [7:0]        mem_data;

   modport master (output mem_addr, output mem_rd_en, input mem_data);
   modport slave  (input mem_addr, input mem_rd_en, output mem_data);
endinterface

// File: rtl/dut_vector_engine_sync.sv
// Two-flop synchronizer for the asynchronous DUT output pins.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/dut_vector_engine.sv
// Vector-driven DUT tester: fetches, applies, settles and checks each vector in a range.
// Optional first-failure capture enabled by macro DVE_FAIL_CAPTURE_EN.
module dut_vector_engine
   import dve_pkg::*;
#(
   parameter int unsigned N_IN          = 4,
   parameter int unsigned N_OUT         = 1,
   parameter int unsigned ADDR_W        = 16,
   parameter int unsigned SETTLE_CYCLES = 100
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [ADDR_W-1:0]    start_addr,
   input  logic [ADDR_W-1:0]    end_addr,
   dut_vector_engine_if.master  mem,
   output logic [N_IN-1:0]      dut_in,
   input  logic [N_OUT-1:0]     dut_out,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [15:0]          mismatch_count,
   output logic [ADDR_W-1:0]    fail_addr,
   output logic [N_OUT-1:0]     fail_actual
);
   localparam int unsigned EXP_LSB = expect_lsb(N_IN);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cur_addr, last_addr;
   logic [N_OUT-1:0]  exp_q, out_sync;
   logic [15:0]       settle_cnt;
   logic              settle_done, mismatch, at_end, aborting;

   sync_2ff #(.WIDTH(N_OUT)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (dut_out),
      .q   (out_sync)
   );

   assign mem.mem_addr = cur_addr;
   assign settle_done  = (settle_cnt == '0);
   assign mismatch     = (out_sync != exp_q);
   assign at_end       = (cur_addr == last_addr);
   assign aborting     = abort && (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      mem.mem_rd_en = 1'b0;
      if (aborting) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state_nxt = (end_addr < start_addr) ? FINISH : FETCH;
            FETCH: begin
               mem.mem_rd_en = 1'b1;
               state_nxt     = WAIT_RD;
            end
            WAIT_RD: state_nxt = SETTLE;
            SETTLE:  if (settle_done) state_nxt = CHECK;
            CHECK:   state_nxt = at_end ? FINISH : FETCH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_addr       <= '0;
         last_addr      <= '0;
         exp_q          <= '0;
         settle_cnt     <= '0;
         dut_in         <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         mismatch_count <= '0;
      end else begin
         done <= 1'b0;
         if (aborting) begin
            busy   <= 1'b0;
            dut_in <= '0;
         end else begin
            case (state)
               IDLE: if (start) begin
                  cur_addr       <= start_addr;
                  last_addr      <= end_addr;
                  mismatch_count <= '0;
                  pass           <= 1'b0;
                  busy           <= 1'b1;
               end
               WAIT_RD: begin
                  dut_in     <= mem.mem_data[DRIVE_LSB +: N_IN];
                  exp_q      <= mem.mem_data[EXP_LSB +: N_OUT];
                  settle_cnt <= 16'(SETTLE_CYCLES - 1);
               end
               SETTLE: if (!settle_done) settle_cnt <= settle_cnt - 1'b1;
               CHECK: begin
                  if (mismatch && (mismatch_count != '1))
                     mismatch_count <= mismatch_count + 1'b1;
                  // Compare before increment so an all-ones end address never wraps.
                  if (!at_end) cur_addr <= cur_addr + 1'b1;
               end
               FINISH: begin
                  done <= 1'b1;
                  pass <= (mismatch_count == '0);
                  busy <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef DVE_FAIL_CAPTURE_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         fail_addr   <= '0;
         fail_actual <= '0;
      end else if (!aborting) begin
         if (state == IDLE && start) begin
            fail_addr   <= '0;
            fail_actual <= '0;
         end else if (state == CHECK && mismatch && mismatch_count == '0) begin
            fail_addr   <= cur_addr;
            fail_actual <= out_sync;
         end
      end
   end
`else
   assign fail_addr   = '0;
   assign fail_actual = '0;
`endif

endmodule
